disp_mode_ctrl: RTL
===================

# disp_mode_ctrl

Display mode controller that sequences the display sync/test-pattern generator: it drives its `enable`, `disp_grey` and `disp_bars` inputs plus a live-video select, all from host mode requests. Every mode change is applied only at a vertical-sync boundary so no torn frame reaches the panel. The block forces a grey start-up interval after power-on of the timing chain. It also watches for lost vertical sync and shuts the chain down with a sticky error.

## Interface
Parameters:
- `STARTUP_FRAMES`, default 2: number of vsync events that grey is forced for after enabling; range 1..255.
- `TIMEOUT_CYCLES`, default 1100000: the number of clocks without a vsync event, while enabled, that declares a timeout.
- `TO_W`, default 21: width of the timeout counter; it must hold `TIMEOUT_CYCLES-1`.

Ports:
- `clk` input 1: pixel clock, the same clock as the sync generator.
- `rst` input 1: asynchronous reset, active-high.
- `req_valid` input 1: a mode request is present.
- `req_mode` input 2: requested mode. 0=OFF, 1=GREY, 2=BARS, 3=LIVE.
- `req_ready` output 1: the block can accept a request this cycle.
- `err_clr` input 1: clears `err_timeout`.
- `vs_n` input 1: active-low vsync from the sync generator.
- `sync_enable` output 1: drives the generator `enable`.
- `disp_grey` output 1: drives the generator `disp_grey`.
- `disp_bars` output 1: drives the generator `disp_bars`.
- `live_sel` output 1: selects the frame-buffer pixel path downstream.
- `cur_mode` output 2: the mode currently applied, using the same encoding as `req_mode`.
- `frame_cnt` output 8: count of vsync events since enabling.
- `err_timeout` output 1: sticky vsync-loss error.

## Operation
- **Vsync event (`vs_evt`).**
  - Defined as `vs_n_d & ~vs_n`, where `vs_n_d` is `vs_n` registered with reset value 1.
  - `vs_evt` is combinational; all state and outputs update on the edge at which it is true.
- **States:**
  - OFF: no mode applied.
  - STARTUP: start-up grey interval in progress.
  - RUN: a mode is applied and no request is pending.
  - PEND: a mode change is waiting for the next vsync event.
  - STOP: shutdown is waiting for the next vsync event.
- **`req_ready`:** high when the state is OFF or RUN and `err_timeout`=0. A request is accepted when `req_valid & req_ready`; the block latches `req_mode` into `tgt_mode`.
- **Transitions:**
  - OFF, accept mode 0: stay in OFF (acknowledged no-op).
  - OFF, accept mode 1-3: go to STARTUP. Set `sync_enable`=1 and `disp_grey`=1, clear the start-up counter and the timeout counter.
  - STARTUP: count `vs_evt`. On the `STARTUP_FRAMES`-th event, apply `tgt_mode` and go to RUN.
  - RUN, accept mode 1-3: go to PEND; outputs are unchanged. On the next `vs_evt`, apply `tgt_mode` and go to RUN. A request for the current mode still waits in PEND.
  - RUN, accept mode 0: go to STOP. On the next `vs_evt`, drop all outputs to 0 and go to OFF.
  - STARTUP, PEND or STOP, when the timeout counter reaches `TIMEOUT_CYCLES-1`: set `err_timeout`=1 and go to OFF with all outputs 0. RUN is also subject to this rule.
- **Output mapping, as (`sync_enable`,`disp_grey`,`disp_bars`,`live_sel`,`cur_mode`):**
  - OFF: (0,0,0,0,0).
  - STARTUP: (1,1,0,0,1).
  - GREY applied: (1,1,0,0,1).
  - BARS applied: (1,0,1,0,2).
  - LIVE applied: (1,0,0,1,3).
  - PEND and STOP hold the previously applied values.
- **`frame_cnt`:**
  - Increments on `vs_evt` while `sync_enable`=1, wrapping from 255 to 0.
  - Cleared to 0 on entry to OFF or STARTUP.
- **Timeout counter:**
  - Increments each cycle while `sync_enable`=1.
  - Cleared on `vs_evt`, on entry to STARTUP, and while in OFF.
- **`err_timeout`:**
  - Cleared by `err_clr`.
  - If a timeout and `err_clr` occur in the same cycle, the set wins.
  - While it is set, `req_ready`=0 and the state stays OFF.

## Timing
- **Reset values:** all outputs are 0 except `req_ready`=1. State is OFF and `vs_n_d`=1.
- **Asynchronous reset:** takes effect immediately, even mid-STARTUP, PEND or STOP. A pending `tgt_mode` is discarded.
- **Request latency:**
  - An accepted request leaves the state at a registered value one clock later.
  - `req_ready` deasserts in the cycle after acceptance.
- **Mode-change latency:** outputs change on the clock edge where `vs_n` is first sampled low after being high. They are visible one cycle after the falling edge of `vs_n` appears at the input.
- **Same-cycle events:**
  - `vs_evt` in the same cycle as a request accepted in RUN: the request goes to PEND and waits for the following `vs_evt`; it is not applied on that same event.
  - `vs_evt` in the same cycle as a timeout: `vs_evt` has priority, the counter clears and no error is raised.
- **Start-up length:** with `STARTUP_FRAMES`=N, grey is shown for exactly N `vs_evt`.
- **Input sampling:** `vs_n` is sampled on every clock, including while in OFF. In OFF, `vs_evt` has no effect.

## Test plan
- **Reset:** assert `rst` with no clock running. All outputs must be 0, `req_ready`=1; release `rst` and hold for 10 cycles with no change.
- **Start-up to BARS:** from OFF, request mode 2 with `STARTUP_FRAMES`=2.
  - From the next cycle: `sync_enable`=1, `disp_grey`=1, `cur_mode`=1.
  - One cycle after the 2nd `vs_n` fall: `disp_grey`=0, `disp_bars`=1, `cur_mode`=2, `frame_cnt`=2.
- **BARS to LIVE mid-frame:** while in RUN/BARS, request mode 3 mid-frame.
  - `req_ready` goes to 0 and outputs are unchanged until the next `vs_n` fall.
  - One cycle after it: `live_sel`=1, `disp_bars`=0, `cur_mode`=3, `req_ready`=1.
- **Shutdown:** while in RUN, request mode 0. One cycle after the next `vs_n` fall: `sync_enable`=0, `frame_cnt`=0, `cur_mode`=0.
- **Timeout:** with `TIMEOUT_CYCLES`=1000, enable and then hold `vs_n`=1.
  - At the 1000th enabled cycle: `err_timeout`=1, all outputs 0, `req_ready`=0.
  - Pulse `err_clr`: `err_timeout`=0, `req_ready`=1.
  - Assert a `vs_n` fall on the same cycle as count 999: no error is raised.
- **Reset mid-operation:** assert `rst` while in PEND. Outputs must return to reset values immediately, and after release the old pending mode is never applied.

Source files
------------

// File: rtl/disp_mode_ctrl.sv
// Display mode sequencer: host mode requests are applied only on vsync boundaries, with forced grey start-up.
// Request seen next cycle; outputs change one cycle after vs_n falls; req_ready drops while a change is pending.
module disp_mode_ctrl #(
   parameter int STARTUP_FRAMES = 2,
   parameter int TIMEOUT_CYCLES = 1100000,
   parameter int TO_W           = 21
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   input  logic [1:0] req_mode,
   output logic       req_ready,
   input  logic       err_clr,
   input  logic       vs_n,
   output logic       sync_enable,
   output logic       disp_grey,
   output logic       disp_bars,
   output logic       live_sel,
   output logic [1:0] cur_mode,
   output logic [7:0] frame_cnt,
   output logic       err_timeout
);

   typedef enum logic [2:0] {S_OFF, S_STARTUP, S_RUN, S_PEND, S_STOP} state_t;

   localparam logic [7:0]      SU_LAST = 8'(STARTUP_FRAMES - 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   state_t          state, state_nx;
   logic            vs_n_d;
   logic            vs_evt;
   logic            accept;
   logic            timeout;
   logic [1:0]      tgt_mode, tgt_nx;
   logic [1:0]      mode_nx;
   logic [7:0]      fc_nx;
   logic [TO_W-1:0] to_cnt, to_nx;
   logic            err_nx;

   assign vs_evt    = vs_n_d & ~vs_n;
   assign req_ready = ((state == S_OFF) || (state == S_RUN)) && !err_timeout;
   assign accept    = req_valid & req_ready;
   // A vsync in the same cycle as the last count rescues the chain.
   assign timeout   = sync_enable & ~vs_evt & (to_cnt == TO_LAST);

   always_comb begin
      state_nx = state;
      tgt_nx   = tgt_mode;
      mode_nx  = cur_mode;
      fc_nx    = frame_cnt;
      to_nx    = '0;
      err_nx   = err_timeout & ~err_clr;
      if (sync_enable) begin
         if (vs_evt) begin
            fc_nx = frame_cnt + 8'd1;
         end else begin
            to_nx = to_cnt + TO_W'(1);
         end
      end
      if (timeout) begin
         err_nx   = 1'b1;
         state_nx = S_OFF;
         mode_nx  = 2'd0;
         fc_nx    = 8'd0;
         to_nx    = '0;
      end else begin
         case (state)
            S_OFF: begin
               if (accept && (req_mode != 2'd0)) begin
                  tgt_nx   = req_mode;
                  state_nx = S_STARTUP;
                  mode_nx  = 2'd1;
                  fc_nx    = 8'd0;
                  to_nx    = '0;
               end
            end
            S_STARTUP: begin
               // frame_cnt was cleared on entry, so it doubles as the start-up counter.
               if (vs_evt && (frame_cnt == SU_LAST)) begin
                  mode_nx  = tgt_mode;
                  state_nx = S_RUN;
               end
            end
            S_RUN: begin
               if (accept) begin
                  tgt_nx   = req_mode;
                  state_nx = (req_mode == 2'd0) ? S_STOP : S_PEND;
               end
            end
            S_PEND: begin
               if (vs_evt) begin
                  mode_nx  = tgt_mode;
                  state_nx = S_RUN;
               end
            end
            S_STOP: begin
               if (vs_evt) begin
                  mode_nx  = 2'd0;
                  fc_nx    = 8'd0;
                  state_nx = S_OFF;
               end
            end
            default: begin
               state_nx = S_OFF;
               mode_nx  = 2'd0;
               fc_nx    = 8'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_OFF;
         vs_n_d      <= 1'b1;
         tgt_mode    <= 2'd0;
         to_cnt      <= '0;
         cur_mode    <= 2'd0;
         frame_cnt   <= 8'd0;
         err_timeout <= 1'b0;
         sync_enable <= 1'b0;
         disp_grey   <= 1'b0;
         disp_bars   <= 1'b0;
         live_sel    <= 1'b0;
      end else begin
         state       <= state_nx;
         vs_n_d      <= vs_n;
         tgt_mode    <= tgt_nx;
         to_cnt      <= to_nx;
         cur_mode    <= mode_nx;
         frame_cnt   <= fc_nx;
         err_timeout <= err_nx;
         sync_enable <= (mode_nx != 2'd0);
         disp_grey   <= (mode_nx == 2'd1);
         disp_bars   <= (mode_nx == 2'd2);
         live_sel    <= (mode_nx == 2'd3);
      end
   end

endmodule
